mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single cache-line memory port between the I-cache (line reads) and the D-cache
//  (line reads and dirty-line writebacks). Sits between both cache miss interfaces and main memory.
//  D-cache has priority; a starvation counter guarantees I-cache forward progress.
//  One transaction is outstanding at a time; the response is routed back to the owner.
// PARAMETERS
//  ADDR_WIDTH    20   physical line address width (paddr_t)
//  LINE_BITS     128  cache line width (cacheline_t, 16 B)
//  STARVE_LIMIT  4    consecutive D grants allowed while I is pending before I is forced (>=1)
// PORTS
//  clk_i          in   1           clock; all logic on posedge
//  rst_i          in   1           synchronous reset, active-high
//  ic_req_i       in   1           I-cache line read request; held until ic_rvalid_o
//  ic_addr_i      in   ADDR_WIDTH  I-cache line address
//  ic_rvalid_o    out  1           one-cycle pulse: ic_rdata_o valid
//  ic_rdata_o     out  LINE_BITS   registered read line
//  dc_req_i       in   1           D-cache request; held until dc_rvalid_o
//  dc_we_i        in   1           1 = line writeback, 0 = line read
//  dc_addr_i      in   ADDR_WIDTH  D-cache line address
//  dc_wdata_i     in   LINE_BITS   writeback line
//  dc_rvalid_o    out  1           one-cycle pulse: read data valid or write complete
//  dc_rdata_o     out  LINE_BITS   registered read line (0 for writes)
//  mem_req_o      out  1           request to memory; held until mem_gnt_i
//  mem_we_o       out  1           write enable to memory
//  mem_addr_o     out  ADDR_WIDTH  latched address
//  mem_wdata_o    out  LINE_BITS   latched write line
//  mem_gnt_i      in   1           memory accepted request
//  mem_rvalid_i   in   1           read line valid on mem_rdata_i
//  mem_rdata_i    in   LINE_BITS   read line
//  mem_wr_done_i  in   1           write completed
//  busy_o         out  1           state != IDLE
//  owner_o        out  1           0 = I-cache, 1 = D-cache (valid while busy_o)
//  ic_grants_o / dc_grants_o / starve_evts_o  out  32  perf counters (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; starve_cnt=0; latched addr/wdata/we cleared.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: arbitration.
//    - Only one requesting -> it wins.
//    - Both requesting -> D wins, unless starve_cnt==STARVE_LIMIT, in which case I wins.
//    - On a grant: latch addr/we/wdata/owner; go to ISSUE.
//    - I requests are always reads (mem_we_o=0).
//  - starve_cnt update:
//    - D grant while ic_req_i=1 -> +1, saturating at STARVE_LIMIT.
//    - Any I grant -> 0.
//    - Otherwise hold.
//  - ISSUE: mem_req_o=1 and latched fields driven. On mem_gnt_i: go to WAIT, except when
//    completion (mem_rvalid_i for reads, mem_wr_done_i for writes) arrives in the same cycle,
//    in which case go straight to RESP.
//  - WAIT: mem_req_o=0. On completion -> RESP, capturing mem_rdata_i (writes capture 0).
//  - RESP: owner's *_rvalid_o=1 for exactly one cycle with registered rdata; other requester's
//    rvalid stays 0. Requests are ignored in RESP. Next state is IDLE.
//  - Latency, uncontended read, gnt at same edge as issue: req sampled in IDLE at cycle N;
//    mem_req_o=1 at N+1; completion at cycle R -> rvalid_o at R+1; next grant evaluated at R+2.
//  - Requester contract: keep req/addr/we/wdata stable until rvalid; drop req the cycle after
//    rvalid. Input changes after the grant edge are ignored (fields are latched).
//  - Completion in IDLE/ISSUE/RESP, and the wrong completion type (wr_done for a read, or
//    vice versa), are ignored.
//  - Reset mid-transaction: return to IDLE immediately, no response pulse; a late memory
//    completion is ignored.
//  - ic_rdata_o/dc_rdata_o hold their last value outside RESP.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined:
//    - ic_grants_o / dc_grants_o: +1 per grant.
//    - starve_evts_o: +1 per forced I grant (starve_cnt==STARVE_LIMIT with dc_req_i=1).
//    - All three wrap at 2^32 and clear on reset.
//  ARB_PERF_CNT_EN undefined: the three ports remain, tied to 0; no counter flops.
// TESTING
//  T1 I read 0x00400, mem gnt at +1, rvalid at +3 with 0xA5..A5 -> ic_rvalid_o=1 one cycle,
//     ic_rdata_o=0xA5..A5, dc_rvalid_o=0, busy_o=0 two cycles after completion.
//  T2 D writeback 0x01230, wdata=0xDEAD..BEEF, mem_wr_done_i at +2 -> mem_we_o=1,
//     mem_addr_o=0x01230, dc_rvalid_o pulse, dc_rdata_o=0.
//  T3 ic_req_i and dc_req_i held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,
//     D,D,D,D,I; with ARB_PERF_CNT_EN, starve_evts_o=2 after 10 transactions.
//  T4 mem_gnt_i and mem_rvalid_i in the same ISSUE cycle -> RESP next cycle, no WAIT state.
//  T5 rst_i asserted during WAIT, completion arrives after reset -> no rvalid pulse,
//     mem_req_o=0, busy_o=0, next request served normally.
//  T6 mem_wr_done_i during a D read and mem_rvalid_i in IDLE -> both ignored, FSM unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single cache-line memory port between I-cache reads and D-cache reads/writebacks.
// Optional perf counters are built only when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 20,
    parameter int LINE_BITS    = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ic_req_i,
    input  logic [ADDR_WIDTH-1:0] ic_addr_i,
    output logic                  ic_rvalid_o,
    output logic [LINE_BITS-1:0]  ic_rdata_o,
    input  logic                  dc_req_i,
    input  logic                  dc_we_i,
    input  logic [ADDR_WIDTH-1:0] dc_addr_i,
    input  logic [LINE_BITS-1:0]  dc_wdata_i,
    output logic                  dc_rvalid_o,
    output logic [LINE_BITS-1:0]  dc_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [LINE_BITS-1:0]  mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [LINE_BITS-1:0]  mem_rdata_i,
    input  logic                  mem_wr_done_i,
    output logic                  busy_o,
    output logic                  owner_o,
    output logic [31:0]           ic_grants_o,
    output logic [31:0]           dc_grants_o,
    output logic [31:0]           starve_evts_o,
    output logic [1:0]            state_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [1:0]            state_q;
    logic                  owner_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_BITS-1:0]  wdata_q;
    logic [SW-1:0]         starve_q;
    logic [LINE_BITS-1:0]  ic_rdata_q;
    logic [LINE_BITS-1:0]  dc_rdata_q;

    logic forced_i;
    logic grant_d;
    logic grant_i;
    logic cmpl;
    logic capture;
    logic [LINE_BITS-1:0] cap_line;

    // Handshake: mem_req_o stays high through ISSUE until mem_gnt_i; the completion pulse of the
    // latched type is accepted in WAIT or together with the grant in ISSUE; requesters hold req
    // until their one-cycle rvalid pulse in RESP.
    assign forced_i = ic_req_i && dc_req_i && (starve_q == STARVE_MAX);
    assign grant_d  = (state_q == IDLE) && dc_req_i && !forced_i;
    assign grant_i  = (state_q == IDLE) && ic_req_i && !grant_d;
    assign cmpl     = we_q ? mem_wr_done_i : mem_rvalid_i;
    assign capture  = cmpl && (((state_q == ISSUE) && mem_gnt_i) || (state_q == WAIT));
    assign cap_line = we_q ? '0 : mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_q   <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        owner_q <= 1'b1;
                        we_q    <= dc_we_i;
                        addr_q  <= dc_addr_i;
                        wdata_q <= dc_wdata_i;
                        state_q <= ISSUE;
                        if (ic_req_i && (starve_q < STARVE_MAX))
                            starve_q <= starve_q + 1'b1;
                    end else if (grant_i) begin
                        owner_q  <= 1'b0;
                        we_q     <= 1'b0;
                        addr_q   <= ic_addr_i;
                        wdata_q  <= '0;
                        starve_q <= '0;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: if (mem_gnt_i) state_q <= cmpl ? RESP : WAIT;
                WAIT:  if (cmpl) state_q <= RESP;
                RESP:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (capture) begin
                if (owner_q) dc_rdata_q <= cap_line;
                else         ic_rdata_q <= cap_line;
            end
        end
    end

    assign mem_req_o   = (state_q == ISSUE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign ic_rvalid_o = (state_q == RESP) && !owner_q;
    assign dc_rvalid_o = (state_q == RESP) && owner_q;
    assign ic_rdata_o  = ic_rdata_q;
    assign dc_rdata_o  = dc_rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign owner_o     = owner_q;
    assign state_o     = state_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] ic_cnt_q;
    logic [31:0] dc_cnt_q;
    logic [31:0] starve_evt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ic_cnt_q     <= '0;
            dc_cnt_q     <= '0;
            starve_evt_q <= '0;
        end else begin
            if (grant_i) ic_cnt_q <= ic_cnt_q + 32'd1;
            if (grant_d) dc_cnt_q <= dc_cnt_q + 32'd1;
            if (grant_i && forced_i) starve_evt_q <= starve_evt_q + 32'd1;
        end
    end

    assign ic_grants_o   = ic_cnt_q;
    assign dc_grants_o   = dc_cnt_q;
    assign starve_evts_o = starve_evt_q;
`else
    assign ic_grants_o   = '0;
    assign dc_grants_o   = '0;
    assign starve_evts_o = '0;
`endif
endmodule
